// File: rtl/tlb_op_unit_pkg.sv
// Shared encodings for the TLB maintenance sequencer: op codes, FSM states, probe result layout.
// Optional feature macro used by this slice: TLB_WIRED_EN (Wired register / Random lower bound).
package tlb_op_unit_pkg;

  localparam logic [1:0] TLBOP_P  = 2'd0;
  localparam logic [1:0] TLBOP_R  = 2'd1;
  localparam logic [1:0] TLBOP_WI = 2'd2;
  localparam logic [1:0] TLBOP_WR = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_PROBE = 2'd3;

  localparam int          PROBE_P_BIT = 31;
  localparam logic [31:0] PROBE_MISS  = 32'b1 << PROBE_P_BIT;

endpackage

// File: rtl/tlb_random.sv
// CP0 Random counter: free-running down-counter over [Wired, ENTRIES-1].
// With TLB_WIRED_EN undefined the Wired register is absent and the range is [0, ENTRIES-1].
module tlb_random
  import tlb_op_unit_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IDX_W-1:0] wired_in,
  input  logic             wired_wen,
  output logic [IDX_W-1:0] random_out
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(ENTRIES - 1);

`ifdef TLB_WIRED_EN
  logic [IDX_W-1:0] wired_q;

  // Reaching or sitting below Wired reloads, which also covers Wired > ENTRIES-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wired_q    <= '0;
      random_out <= TOP;
    end else if (wired_wen) begin
      wired_q    <= wired_in;
      random_out <= TOP;
    end else if (random_out <= wired_q) begin
      random_out <= TOP;
    end else begin
      random_out <= random_out - IDX_W'(1);
    end
  end
`else
  logic unused_wired;
  assign unused_wired = ^{wired_in, wired_wen};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random_out <= TOP;
    end else if (random_out == '0) begin
      random_out <= TOP;
    end else begin
      random_out <= random_out - IDX_W'(1);
    end
  end
`endif

endmodule

// File: rtl/tlb_op_unit.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR against a single-ported TLB array; probe is a serial scan.
// Define TLB_WIRED_EN to enable the Wired register in the Random counter.
module tlb_op_unit
  import tlb_op_unit_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req,
  input  logic [1:0]       op,
  output logic             ready,
  output logic             done,
  input  logic [IDX_W-1:0] index_in,
  input  logic [31:0]      entryhi_in,
  input  logic [31:0]      entrylo0_in,
  input  logic [31:0]      entrylo1_in,
  input  logic [11:0]      pagemask_in,
  input  logic [IDX_W-1:0] wired_in,
  input  logic             wired_wen,
  output logic [IDX_W-1:0] random_out,
  output logic [31:0]      probe_index,
  output logic [31:0]      rd_entryhi,
  output logic [31:0]      rd_entrylo0,
  output logic [31:0]      rd_entrylo1,
  output logic [11:0]      rd_pagemask,
  output logic             tlb_wen,
  output logic [5:0]       tlb_idx,
  output logic [11:0]      tlb_mask,
  output logic [31:0]      tlb_entryhi,
  output logic [31:0]      tlb_entrylo0,
  output logic [31:0]      tlb_entrylo1,
  output logic [IDX_W-1:0] tlb_ridx,
  input  logic [11:0]      tlb_rmask,
  input  logic [31:0]      tlb_rentryhi,
  input  logic [31:0]      tlb_rentrylo0,
  input  logic [31:0]      tlb_rentrylo1
);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] scan_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo0_q;
  logic [31:0]      lo1_q;
  logic [11:0]      mask_q;
  logic [18:0]      vpn_keep;
  logic             probe_hit;
  logic             scan_last;
  logic             unused_rhi;

  tlb_random #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_random (
    .clk        (clk),
    .resetn     (resetn),
    .wired_in   (wired_in),
    .wired_wen  (wired_wen),
    .random_out (random_out)
  );

  // PageMask covers VPN2 bits [24:13]; the upper seven VPN2 bits always take part.
  assign vpn_keep  = ~{7'b0, tlb_rmask};
  assign probe_hit = ((hi_q[31:13] & vpn_keep) == (tlb_rentryhi[31:13] & vpn_keep)) &&
                     (tlb_rentrylo0[0] || (tlb_rentryhi[7:0] == hi_q[7:0]));
  assign scan_last = (scan_q == IDX_W'(ENTRIES - 1));

  assign ready        = (state == ST_IDLE);
  assign tlb_wen      = (state == ST_WRITE);
  assign done         = (state == ST_WRITE) || (state == ST_READ) ||
                        ((state == ST_PROBE) && (probe_hit || scan_last));
  assign tlb_idx      = 6'(idx_q);
  assign tlb_mask     = mask_q;
  assign tlb_entryhi  = hi_q;
  assign tlb_entrylo0 = lo0_q;
  assign tlb_entrylo1 = lo1_q;
  assign tlb_ridx     = (state == ST_PROBE) ? scan_q : idx_q;
  assign unused_rhi   = ^tlb_rentryhi[12:8];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      idx_q       <= '0;
      scan_q      <= '0;
      hi_q        <= '0;
      lo0_q       <= '0;
      lo1_q       <= '0;
      mask_q      <= '0;
      probe_index <= '0;
      rd_entryhi  <= '0;
      rd_entrylo0 <= '0;
      rd_entrylo1 <= '0;
      rd_pagemask <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            hi_q   <= entryhi_in;
            lo0_q  <= entrylo0_in;
            lo1_q  <= entrylo1_in;
            mask_q <= pagemask_in;
            scan_q <= '0;
            case (op)
              TLBOP_P:  state <= ST_PROBE;
              TLBOP_R:  begin idx_q <= index_in;   state <= ST_READ;  end
              TLBOP_WI: begin idx_q <= index_in;   state <= ST_WRITE; end
              default:  begin idx_q <= random_out; state <= ST_WRITE; end
            endcase
          end
        end
        ST_WRITE: state <= ST_IDLE;
        ST_READ: begin
          rd_entryhi  <= {tlb_rentryhi[31:13], 5'b0, tlb_rentryhi[7:0]};
          rd_entrylo0 <= tlb_rentrylo0;
          rd_entrylo1 <= tlb_rentrylo1;
          rd_pagemask <= tlb_rmask;
          state       <= ST_IDLE;
        end
        ST_PROBE: begin
          if (probe_hit) begin
            probe_index <= 32'(scan_q);
            state       <= ST_IDLE;
          end else if (scan_last) begin
            probe_index <= PROBE_MISS;
            state       <= ST_IDLE;
          end else begin
            scan_q <= scan_q + IDX_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_unit.sv
// Directed self-checking bench for tlb_op_unit with a behavioural 32-entry TLB array.
// Covers the Wired path when built with TLB_WIRED_EN defined.
module tb_tlb_op_unit;

  localparam int ENTRIES = 32;
  localparam int IDX_W   = 5;

  logic             clk = 1'b0;
  logic             resetn;
  logic             req;
  logic [1:0]       op;
  logic             ready, done;
  logic [IDX_W-1:0] index_in;
  logic [31:0]      entryhi_in, entrylo0_in, entrylo1_in;
  logic [11:0]      pagemask_in;
  logic [IDX_W-1:0] wired_in;
  logic             wired_wen;
  logic [IDX_W-1:0] random_out;
  logic [31:0]      probe_index;
  logic [31:0]      rd_entryhi, rd_entrylo0, rd_entrylo1;
  logic [11:0]      rd_pagemask;
  logic             tlb_wen;
  logic [5:0]       tlb_idx;
  logic [11:0]      tlb_mask;
  logic [31:0]      tlb_entryhi, tlb_entrylo0, tlb_entrylo1;
  logic [IDX_W-1:0] tlb_ridx;
  logic [11:0]      tlb_rmask;
  logic [31:0]      tlb_rentryhi, tlb_rentrylo0, tlb_rentrylo1;

  logic [11:0] mem_mask [ENTRIES];
  logic [31:0] mem_hi   [ENTRIES];
  logic [31:0] mem_lo0  [ENTRIES];
  logic [31:0] mem_lo1  [ENTRIES];

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;
  int wen_seen    = 0;

  always #5 clk = ~clk;

  tlb_op_unit #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req           (req),
    .op            (op),
    .ready         (ready),
    .done          (done),
    .index_in      (index_in),
    .entryhi_in    (entryhi_in),
    .entrylo0_in   (entrylo0_in),
    .entrylo1_in   (entrylo1_in),
    .pagemask_in   (pagemask_in),
    .wired_in      (wired_in),
    .wired_wen     (wired_wen),
    .random_out    (random_out),
    .probe_index   (probe_index),
    .rd_entryhi    (rd_entryhi),
    .rd_entrylo0   (rd_entrylo0),
    .rd_entrylo1   (rd_entrylo1),
    .rd_pagemask   (rd_pagemask),
    .tlb_wen       (tlb_wen),
    .tlb_idx       (tlb_idx),
    .tlb_mask      (tlb_mask),
    .tlb_entryhi   (tlb_entryhi),
    .tlb_entrylo0  (tlb_entrylo0),
    .tlb_entrylo1  (tlb_entrylo1),
    .tlb_ridx      (tlb_ridx),
    .tlb_rmask     (tlb_rmask),
    .tlb_rentryhi  (tlb_rentryhi),
    .tlb_rentrylo0 (tlb_rentrylo0),
    .tlb_rentrylo1 (tlb_rentrylo1)
  );

  // Behavioural array: synchronous write, combinational read.
  always @(posedge clk) begin
    if (tlb_wen === 1'b1) begin
      mem_mask[tlb_idx[IDX_W-1:0]] <= tlb_mask;
      mem_hi[tlb_idx[IDX_W-1:0]]   <= tlb_entryhi;
      mem_lo0[tlb_idx[IDX_W-1:0]]  <= tlb_entrylo0;
      mem_lo1[tlb_idx[IDX_W-1:0]]  <= tlb_entrylo1;
    end
  end

  assign tlb_rmask     = mem_mask[tlb_ridx];
  assign tlb_rentryhi  = mem_hi[tlb_ridx];
  assign tlb_rentrylo0 = mem_lo0[tlb_ridx];
  assign tlb_rentrylo1 = mem_lo1[tlb_ridx];

  always @(negedge clk) begin
    if (done === 1'b1)    done_seen++;
    if (tlb_wen === 1'b1) wen_seen++;
  end

  // Drives one request, returns just after the accept edge with inputs scrambled.
  task automatic issue(input logic [1:0] o, input logic [IDX_W-1:0] i,
                       input logic [31:0] hi, input logic [31:0] lo0,
                       input logic [31:0] lo1, input logic [11:0] m);
    req = 1'b1; op = o; index_in = i;
    entryhi_in = hi; entrylo0_in = lo0; entrylo1_in = lo1; pagemask_in = m;
    @(posedge clk); #1;
    req = 1'b0; op = 2'd2; index_in = 5'd31;
    entryhi_in = 32'hDEAD_BEEF; entrylo0_in = 32'hFFFF_FFFF;
    entrylo1_in = 32'h5555_5555; pagemask_in = 12'hFFF;
  endtask

  task automatic write_entry(input logic [IDX_W-1:0] i, input logic [31:0] hi,
                             input logic [31:0] lo0, input logic [11:0] m);
    issue(2'd2, i, hi, lo0, 32'h0, m);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0; req = 1'b0; op = 2'd0; index_in = '0;
    entryhi_in = '0; entrylo0_in = '0; entrylo1_in = '0; pagemask_in = '0;
    wired_in = '0; wired_wen = 1'b0;
    for (int k = 0; k < ENTRIES; k++) begin
      mem_mask[k] = '0; mem_hi[k] = '0; mem_lo0[k] = '0; mem_lo1[k] = '0;
    end
    repeat (3) @(negedge clk);
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 1", ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
    vectors++; if (tlb_wen !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wen got %b want 0", tlb_wen); end
    vectors++; if (probe_index !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_probe got %h want 0", probe_index); end
    vectors++; if (rd_entryhi !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdhi got %h want 0", rd_entryhi); end
    vectors++; if (rd_pagemask !== 12'h0) begin miscompares++; $display("[TB] FAIL reset_rdmask got %h want 0", rd_pagemask); end
    vectors++; if (random_out !== 5'd31) begin miscompares++; $display("[TB] FAIL reset_random got %0d want 31", random_out); end
    vectors++; if (tlb_ridx !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_ridx got %0d want 0", tlb_ridx); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_wi;
    issue(2'd2, 5'd5, 32'h0040_2003, 32'h0000_1017, 32'h0000_2017, 12'h000);
    @(negedge clk);
    vectors++; if (tlb_wen !== 1'b1) begin miscompares++; $display("[TB] FAIL wi_wen got %b want 1", tlb_wen); end
    vectors++; if (tlb_idx !== 6'd5) begin miscompares++; $display("[TB] FAIL wi_idx got %0d want 5", tlb_idx); end
    vectors++; if (tlb_entryhi !== 32'h0040_2003) begin miscompares++; $display("[TB] FAIL wi_hi got %h want 00402003", tlb_entryhi); end
    vectors++; if (tlb_entrylo0 !== 32'h0000_1017) begin miscompares++; $display("[TB] FAIL wi_lo0 got %h want 00001017", tlb_entrylo0); end
    vectors++; if (tlb_entrylo1 !== 32'h0000_2017) begin miscompares++; $display("[TB] FAIL wi_lo1 got %h want 00002017", tlb_entrylo1); end
    vectors++; if (tlb_mask !== 12'h000) begin miscompares++; $display("[TB] FAIL wi_mask got %h want 000", tlb_mask); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL wi_done got %b want 1", done); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("[TB] FAIL wi_ready_t1 got %b want 0", ready); end
    @(negedge clk);
    vectors++; if (tlb_wen !== 1'b0) begin miscompares++; $display("[TB] FAIL wi_wen_t2 got %b want 0", tlb_wen); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL wi_done_t2 got %b want 0", done); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wi_ready_t2 got %b want 1", ready); end
  endtask

  task automatic test_read;
    write_entry(5'd20, 32'h1234_5F7A, 32'h0000_0F1F, 12'h003);
    mem_lo1[20] = 32'h0000_0E2E;
    issue(2'd1, 5'd20, 32'h0, 32'h0, 32'h0, 12'h0);
    @(negedge clk);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_done got %b want 1", done); end
    vectors++; if (tlb_ridx !== 5'd20) begin miscompares++; $display("[TB] FAIL rd_ridx got %0d want 20", tlb_ridx); end
    @(negedge clk);
    vectors++; if (rd_entryhi !== 32'h1234_407A) begin miscompares++; $display("[TB] FAIL rd_hi got %h want 1234407a", rd_entryhi); end
    vectors++; if (rd_entrylo0 !== 32'h0000_0F1F) begin miscompares++; $display("[TB] FAIL rd_lo0 got %h want 00000f1f", rd_entrylo0); end
    vectors++; if (rd_entrylo1 !== 32'h0000_0E2E) begin miscompares++; $display("[TB] FAIL rd_lo1 got %h want 00000e2e", rd_entrylo1); end
    vectors++; if (rd_pagemask !== 12'h003) begin miscompares++; $display("[TB] FAIL rd_mask got %h want 003", rd_pagemask); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_ready got %b want 1", ready); end
  endtask

  task automatic test_probe_hit;
    int n;
    write_entry(5'd3, 32'h0040_2003, 32'h0000_1016, 12'h000);
    write_entry(5'd9, 32'h0040_2003, 32'h0000_1016, 12'h000);
    issue(2'd0, 5'd0, 32'h0040_2003, 32'h0, 32'h0, 12'h0);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin n = c; break; end
    end
    vectors++; if (n != 4) begin miscompares++; $display("[TB] FAIL probe_hit_cycle got %0d want 4", n); end
    @(negedge clk);
    vectors++; if (probe_index !== 32'd3) begin miscompares++; $display("[TB] FAIL probe_hit_index got %h want 3", probe_index); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL probe_hit_ready got %b want 1", ready); end
    vectors++; if (rd_entryhi !== 32'h1234_407A) begin miscompares++; $display("[TB] FAIL rd_hold got %h want 1234407a", rd_entryhi); end
  endtask

  task automatic test_probe_miss;
    int n;
    write_entry(5'd5, 32'h0080_0003, 32'h0000_0001, 12'h000);
    issue(2'd0, 5'd0, 32'h0040_2007, 32'h0, 32'h0, 12'h0);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin n = c; break; end
    end
    vectors++; if (n != 32) begin miscompares++; $display("[TB] FAIL probe_miss_cycle got %0d want 32", n); end
    @(negedge clk);
    vectors++; if (probe_index !== 32'h8000_0000) begin miscompares++; $display("[TB] FAIL probe_miss_index got %h want 80000000", probe_index); end
  endtask

  task automatic test_probe_global;
    int n;
    write_entry(5'd9, 32'h0040_2003, 32'h0000_1017, 12'h000);
    issue(2'd0, 5'd0, 32'h0040_2007, 32'h0, 32'h0, 12'h0);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin n = c; break; end
    end
    vectors++; if (n != 10) begin miscompares++; $display("[TB] FAIL probe_g_cycle got %0d want 10", n); end
    @(negedge clk);
    vectors++; if (probe_index !== 32'd9) begin miscompares++; $display("[TB] FAIL probe_g_index got %h want 9", probe_index); end
  endtask

  task automatic test_probe_mask;
    int n;
    write_entry(5'd12, 32'h0040_6005, 32'h0000_0002, 12'h003);
    issue(2'd0, 5'd0, 32'h0040_0005, 32'h0, 32'h0, 12'h0);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin n = c; break; end
    end
    vectors++; if (n != 13) begin miscompares++; $display("[TB] FAIL probe_mask_cycle got %0d want 13", n); end
    @(negedge clk);
    vectors++; if (probe_index !== 32'd12) begin miscompares++; $display("[TB] FAIL probe_mask_index got %h want c", probe_index); end
  endtask

  task automatic test_random;
    logic [IDX_W-1:0] exp_r;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      exp_r = 5'(31 - (i % 32));
      vectors++; if (random_out !== exp_r) begin miscompares++; $display("[TB] FAIL random_seq[%0d] got %0d want %0d", i, random_out, exp_r); end
      @(negedge clk);
    end
    repeat (11) @(negedge clk);
    issue(2'd3, 5'd0, 32'hFFFF_E0AA, 32'h0, 32'h0, 12'h0);
    @(negedge clk);
    vectors++; if (tlb_wen !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_wen got %b want 1", tlb_wen); end
    vectors++; if (tlb_idx !== 6'd12) begin miscompares++; $display("[TB] FAIL wr_idx got %0d want 12", tlb_idx); end
    vectors++; if (random_out !== 5'd11) begin miscompares++; $display("[TB] FAIL wr_random got %0d want 11", random_out); end
    @(negedge clk);
  endtask

`ifdef TLB_WIRED_EN
  task automatic test_wired;
    logic [IDX_W-1:0] exp_r;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    wired_in = 5'd8; wired_wen = 1'b1;
    @(posedge clk); #1;
    wired_wen = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 25; j++) begin
      exp_r = (j <= 23) ? 5'(31 - j) : 5'(31 - (j - 24));
      vectors++; if (random_out !== exp_r) begin miscompares++; $display("[TB] FAIL wired_seq[%0d] got %0d want %0d", j, random_out, exp_r); end
      @(negedge clk);
    end
    wired_in = 5'd0; wired_wen = 1'b1;
    issue(2'd3, 5'd0, 32'h0, 32'h0, 32'h0, 12'h0);
    wired_wen = 1'b0;
    @(negedge clk);
    vectors++; if (tlb_idx !== 6'd30) begin miscompares++; $display("[TB] FAIL wired_wr_idx got %0d want 30", tlb_idx); end
    vectors++; if (tlb_wen !== 1'b1) begin miscompares++; $display("[TB] FAIL wired_wr_wen got %b want 1", tlb_wen); end
    vectors++; if (random_out !== 5'd31) begin miscompares++; $display("[TB] FAIL wired_wr_reload got %0d want 31", random_out); end
    @(negedge clk);
  endtask
`else
  task automatic test_wired;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    wired_in = 5'd8; wired_wen = 1'b1;
    @(posedge clk); #1;
    wired_wen = 1'b0;
    @(negedge clk);
    vectors++; if (random_out !== 5'd27) begin miscompares++; $display("[TB] FAIL nowired_next got %0d want 27", random_out); end
    repeat (22) @(negedge clk);
    vectors++; if (random_out !== 5'd5) begin miscompares++; $display("[TB] FAIL nowired_below got %0d want 5", random_out); end
  endtask
`endif

  task automatic test_reset_mid_op;
    int d0, w0;
    @(negedge clk);
    d0 = done_seen; w0 = wen_seen;
    issue(2'd0, 5'd0, 32'h0040_2007, 32'h0, 32'h0, 12'h0);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_ready got %b want 1", ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_done got %b want 0", done); end
    vectors++; if (probe_index !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_probe got %h want 0", probe_index); end
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    vectors++; if (done_seen != d0) begin miscompares++; $display("[TB] FAIL abort_done_count got %0d want %0d", done_seen, d0); end
    vectors++; if (wen_seen != w0) begin miscompares++; $display("[TB] FAIL abort_wen_count got %0d want %0d", wen_seen, w0); end
    vectors++; if (probe_index !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_probe_after got %h want 0", probe_index); end
  endtask

  initial begin
    test_reset();
    test_write_wi();
    test_read();
    test_probe_hit();
    test_probe_miss();
    test_probe_global();
    test_random();
    test_wired();
    test_probe_mask();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
